// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its three requesters and the external SRAM.
// The arbiter uses the slave modport; the requester/SRAM side uses master.
interface sram_arbiter_if;
  logic        p_req;
  logic        p_we;
  logic [18:0] p_add;
  logic [7:0]  p_di;
  logic        p_ack;

  logic        c_req;
  logic        c_we;
  logic [18:0] c_add;
  logic [7:0]  c_di;
  logic [7:0]  c_do;
  logic        c_ack;

  logic        v_req;
  logic [18:0] v_add;
  logic [7:0]  v_do;
  logic        v_ack;

  logic [18:0] ER_ADD;
  logic [7:0]  ER_DO;
  logic [7:0]  ER_DI;
  logic        ER_DOE;
  logic        ER_CS;
  logic        ER_OE;
  logic        ER_WE;

  logic [1:0]  grant;

  modport slave (
    input  p_req, p_we, p_add, p_di,
    input  c_req, c_we, c_add, c_di,
    input  v_req, v_add,
    input  ER_DI,
    output p_ack, c_do, c_ack, v_do, v_ack,
    output ER_ADD, ER_DO, ER_DOE, ER_CS, ER_OE, ER_WE,
    output grant
  );

  modport master (
    output p_req, p_we, p_add, p_di,
    output c_req, c_we, c_add, c_di,
    output v_req, v_add,
    output ER_DI,
    input  p_ack, c_do, c_ack, v_do, v_ack,
    input  ER_ADD, ER_DO, ER_DOE, ER_CS, ER_OE, ER_WE,
    input  grant
  );
endinterface

// File: rtl/sram_arbiter.sv
// Three-way SRAM arbiter (programmer > CPU > video, with video starvation promotion)
// driving one asynchronous SRAM through an IDLE -> ACCESS -> ACK sequence.
module sram_arbiter #(
  parameter int ACC_CYCLES = 2,
  parameter int STARVE     = 8
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus,
  output logic [1:0]     dbg_state
);

  // Handshake: a requester raises req with stable operands and holds them until its
  // one-clock ack; a req still high in the IDLE clock after ack starts a new access.

  localparam int SW = $clog2(STARVE + 1);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_PROG = 2'd1;
  localparam logic [1:0] G_CPU  = 2'd2;
  localparam logic [1:0] G_VID  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [3:0]     acc_cnt;
  logic [1:0]     owner;
  logic [1:0]     winner;
  logic [18:0]    lat_add;
  logic [7:0]     lat_do;
  logic           lat_we;
  logic [SW-1:0]  starve_cnt;
  logic           starved;
  logic           last_acc;
  logic           in_acc;

  assign starved  = (starve_cnt == SW'(STARVE));
  assign last_acc = (acc_cnt == 4'(ACC_CYCLES - 1));
  assign in_acc   = (state == ACCESS);

  // A starved video request jumps the CPU but never the programmer.
  always_comb begin
    winner = G_NONE;
    if (bus.p_req)                 winner = G_PROG;
    else if (bus.v_req && starved) winner = G_VID;
    else if (bus.c_req)            winner = G_CPU;
    else if (bus.v_req)            winner = G_VID;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (winner != G_NONE) state_nxt = ACCESS;
      ACCESS:  if (last_acc)         state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= '0;
      owner    <= G_NONE;
      lat_add  <= '0;
      lat_do   <= '0;
      lat_we   <= 1'b0;
      bus.c_do <= 8'h00;
      bus.v_do <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          acc_cnt <= '0;
          if (winner != G_NONE) owner <= winner;
          case (winner)
            G_PROG: begin
              lat_add <= bus.p_add;
              lat_do  <= bus.p_di;
              lat_we  <= bus.p_we;
            end
            G_CPU: begin
              lat_add <= bus.c_add;
              lat_do  <= bus.c_di;
              lat_we  <= bus.c_we;
            end
            G_VID: begin
              lat_add <= bus.v_add;
              lat_we  <= 1'b0;
            end
            default: ;
          endcase
        end
        ACCESS: begin
          acc_cnt <= acc_cnt + 4'd1;
          // Read data is taken on the last strobe clock so it is valid during ACK.
          if (last_acc && !lat_we) begin
            if (owner == G_CPU) bus.c_do <= bus.ER_DI;
            if (owner == G_VID) bus.v_do <= bus.ER_DI;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!bus.v_req || (state == IDLE && winner == G_VID) ||
             (state != IDLE && owner == G_VID))
      starve_cnt <= '0;
    else if (!starved)
      starve_cnt <= starve_cnt + 1'b1;
  end

  // WE is released one clock before the end of a write so data hold is met.
  assign bus.ER_ADD = lat_add;
  assign bus.ER_DO  = lat_do;
  assign bus.ER_CS  = !in_acc;
  assign bus.ER_OE  = !(in_acc && !lat_we);
  assign bus.ER_WE  = !(in_acc && lat_we && !last_acc);
  assign bus.ER_DOE = in_acc && lat_we;

  assign bus.grant  = (state == IDLE) ? G_NONE : owner;
  assign bus.p_ack  = (state == ACK) && (owner == G_PROG);
  assign bus.c_ack  = (state == ACK) && (owner == G_CPU);
  assign bus.v_ack  = (state == ACK) && (owner == G_VID);

  assign dbg_state  = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random three-requester traffic,
// with an SRAM model, an issue-time reference model and a queue-based ack monitor.
module tb_sram_arbiter;
  localparam int ACC = 2;
  localparam int STV = 8;
  localparam int TMO = 200;
  localparam int NRND = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  sram_arbiter_if bus();

  sram_arbiter #(.ACC_CYCLES(ACC), .STARVE(STV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 400000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SRAM model and reference model ----------------
  logic [7:0] sram_mem[logic [18:0]];
  logic [7:0] ref_mem[logic [18:0]];

  function automatic logic [7:0] init_val(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  initial begin
    bus.ER_DI = 8'h00;
    forever begin
      @(negedge clk);
      if (!bus.ER_CS && !bus.ER_WE) sram_mem[bus.ER_ADD] = bus.ER_DO;
      bus.ER_DI = sram_mem.exists(bus.ER_ADD) ? sram_mem[bus.ER_ADD] : init_val(bus.ER_ADD);
    end
  end

  // Expected entries: {we, addr[18:0], data[7:0]}
  logic [27:0] exp_p_q[$];
  logic [27:0] exp_c_q[$];
  logic [27:0] exp_v_q[$];

  // ---------------- driver tasks ----------------
  function automatic logic ack_of(input int who);
    case (who)
      1:       return bus.p_ack;
      2:       return bus.c_ack;
      default: return bus.v_ack;
    endcase
  endfunction

  // Called at a negedge; leaves req high on return so the caller decides to chain or drop.
  task automatic do_req(input int who, input logic we, input logic [18:0] a,
                        input logic [7:0] d, output int lat);
    logic [7:0] ed;
    ed = d;
    case (who)
      1: begin
        if (we) ref_mem[a] = d; else ed = 8'h00;
        exp_p_q.push_back({we, a, ed});
        bus.p_we = we; bus.p_add = a; bus.p_di = d; bus.p_req = 1'b1;
      end
      2: begin
        if (we) ref_mem[a] = d; else ed = ref_rd(a);
        exp_c_q.push_back({we, a, ed});
        bus.c_we = we; bus.c_add = a; bus.c_di = d; bus.c_req = 1'b1;
      end
      default: begin
        ed = ref_rd(a);
        exp_v_q.push_back({1'b0, a, ed});
        bus.v_add = a; bus.v_req = 1'b1;
      end
    endcase
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_of(who) && lat < TMO);
    if (!ack_of(who)) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: requester %0d got no ack after %0d cycles, expected ack", who, lat);
    end
  endtask

  task automatic drop(input int who);
    case (who)
      1:       bus.p_req = 1'b0;
      2:       bus.c_req = 1'b0;
      default: bus.v_req = 1'b0;
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          cs_cnt = 0, oe_cnt = 0, we_cnt = 0, doe_cnt = 0;
  logic [18:0] m_add = '0;
  logic [7:0]  m_do = '0;
  logic [1:0]  m_grant = '0;
  logic [7:0]  last_c_rd = 8'h00;
  logic [7:0]  last_v_rd = 8'h00;
  int          start_log[$];
  int          grant_log[$];

  initial begin
    int          n_ack;
    int          who;
    logic [27:0] e;
    logic        have;
    forever begin
      @(negedge clk);
      if (rst) begin
        cs_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0;
        last_c_rd = 8'h00; last_v_rd = 8'h00;
      end else begin
        n_ack = int'(bus.p_ack) + int'(bus.c_ack) + int'(bus.v_ack);
        check("we_oe_overlap", 32'(!bus.ER_WE && !bus.ER_OE), 32'd0);
        check("ack_onehot0", 32'(n_ack > 1), 32'd0);
        if (!bus.ER_CS) begin
          if (cs_cnt == 0) begin
            m_add = bus.ER_ADD; m_do = bus.ER_DO; m_grant = bus.grant;
            start_log.push_back(cyc);
            grant_log.push_back(int'(bus.grant));
          end else begin
            check("addr_stable", 32'(bus.ER_ADD), 32'(m_add));
            if (bus.ER_DOE) check("do_stable", 32'(bus.ER_DO), 32'(m_do));
          end
          check("grant_active", 32'(bus.grant != 2'd0), 32'd1);
          cs_cnt++;
          if (!bus.ER_OE) oe_cnt++;
          if (!bus.ER_WE) we_cnt++;
          if (bus.ER_DOE) doe_cnt++;
        end else begin
          check("doe_idle", 32'(bus.ER_DOE), 32'd0);
          check("strobes_idle", 32'({bus.ER_OE, bus.ER_WE}), 32'd3);
          if (n_ack == 0) begin
            check("grant_idle", 32'(bus.grant), 32'd0);
            cs_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0;
          end
        end
        if (n_ack == 1) begin
          who = bus.p_ack ? 1 : (bus.c_ack ? 2 : 3);
          check("ack_owner", 32'(bus.grant), 32'(who));
          check("ack_vs_access", 32'(m_grant), 32'(who));
          have = 1'b1;
          e = '0;
          case (who)
            1: if (exp_p_q.size() > 0) e = exp_p_q.pop_front(); else have = 1'b0;
            2: if (exp_c_q.size() > 0) e = exp_c_q.pop_front(); else have = 1'b0;
            default: if (exp_v_q.size() > 0) e = exp_v_q.pop_front(); else have = 1'b0;
          endcase
          if (!have) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ack: requester %0d acked, expected no outstanding request", who);
          end else begin
            check("acc_add", 32'(m_add), 32'(e[26:8]));
            check("acc_len", 32'(cs_cnt), 32'(ACC));
            check("oe_len", 32'(oe_cnt), e[27] ? 32'd0 : 32'(ACC));
            check("we_len", 32'(we_cnt), e[27] ? 32'(ACC - 1) : 32'd0);
            check("doe_len", 32'(doe_cnt), e[27] ? 32'(ACC) : 32'd0);
            if (e[27]) check("wr_data", 32'(m_do), 32'(e[7:0]));
            if (who == 2 && !e[27]) begin
              check("c_do", 32'(bus.c_do), 32'(e[7:0]));
              last_c_rd = e[7:0];
            end else begin
              check("c_do_hold", 32'(bus.c_do), 32'(last_c_rd));
            end
            if (who == 3) begin
              check("v_do", 32'(bus.v_do), 32'(e[7:0]));
              last_v_rd = e[7:0];
            end else begin
              check("v_do_hold", 32'(bus.v_do), 32'(last_v_rd));
            end
          end
          cs_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, lp, lc, lv, c_acks_before, exp_cpu;
    bit v_done;
    bus.p_req = 0; bus.p_we = 0; bus.p_add = '0; bus.p_di = '0;
    bus.c_req = 0; bus.c_we = 0; bus.c_add = '0; bus.c_di = '0;
    bus.v_req = 0; bus.v_add = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(bus.ER_CS), 32'd1);
    check("rst_oe", 32'(bus.ER_OE), 32'd1);
    check("rst_we", 32'(bus.ER_WE), 32'd1);
    check("rst_doe", 32'(bus.ER_DOE), 32'd0);
    check("rst_acks", 32'({bus.p_ack, bus.c_ack, bus.v_ack}), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_c_do", 32'(bus.c_do), 32'h00);
    check("rst_v_do", 32'(bus.v_do), 32'h00);
    check("rst_er_add", 32'(bus.ER_ADD), 32'd0);
    check("rst_er_do", 32'(bus.ER_DO), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // CPU read with preset SRAM content
    sram_mem[19'h0F800] = 8'hC3;
    ref_mem[19'h0F800]  = 8'hC3;
    do_req(2, 1'b0, 19'h0F800, 8'h00, lat);
    drop(2);
    check("c_rd_latency", 32'(lat), 32'(ACC + 1));
    check("c_do_0F800", 32'(bus.c_do), 32'hC3);

    // Programmer write at top of memory
    @(negedge clk);
    do_req(1, 1'b1, 19'h7FFFF, 8'hA5, lat);
    drop(1);
    check("p_wr_latency", 32'(lat), 32'(ACC + 1));
    check("sram_7FFFF", 32'(sram_mem.exists(19'h7FFFF) ? sram_mem[19'h7FFFF] : 8'h00), 32'hA5);

    // All three at once: priority order, one IDLE clock between grants
    @(negedge clk);
    start_log.delete();
    grant_log.delete();
    fork
      begin do_req(1, 1'b1, 19'h60010, 8'h11, lp); drop(1); end
      begin do_req(2, 1'b0, 19'h00005, 8'h00, lc); drop(2); end
      begin do_req(3, 1'b0, 19'h20020, 8'h00, lv); drop(3); end
    join
    check("seq_len", 32'(grant_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < grant_log.size()) check("seq_grant", 32'(grant_log[i]), 32'(i + 1));
    for (int i = 1; i < 3; i++)
      if (i < start_log.size()) check("seq_gap", 32'(start_log[i] - start_log[i-1]), 32'(ACC + 2));

    // Starvation: CPU hammers continuously while video waits
    @(negedge clk);
    c_acks_before = 0;
    v_done = 1'b0;
    fork
      begin do_req(3, 1'b0, 19'h21234, 8'h00, lv); drop(3); v_done = 1'b1; end
      begin
        while (!v_done) begin
          do_req(2, 1'b0, {15'h0, 4'($urandom)}, 8'h00, lc);
          if (!v_done) c_acks_before++;
        end
        drop(2);
      end
    join
    exp_cpu = (STV + ACC + 1) / (ACC + 2);
    check("starve_cpu_acks", 32'(c_acks_before), 32'(exp_cpu));

    // Reset in the second ACCESS clock of a CPU write, then re-arbitration
    repeat (2) @(negedge clk);
    fork
      begin do_req(2, 1'b1, 19'h00123, 8'h3C, lc); drop(2); end
      begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", 32'(bus.ER_CS), 32'd1);
        check("abort_strobes", 32'({bus.ER_OE, bus.ER_WE}), 32'd3);
        check("abort_doe", 32'(bus.ER_DOE), 32'd0);
        check("abort_grant", 32'(bus.grant), 32'd0);
        check("abort_c_ack", 32'(bus.c_ack), 32'd0);
        check("abort_c_do", 32'(bus.c_do), 32'h00);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    check("abort_retry_latency", 32'(lc), 32'(ACC + 5));

    // Random concurrent traffic
    fork
      begin
        int l;
        repeat (NRND) begin
          repeat ($urandom_range(0, 6)) @(negedge clk);
          @(negedge clk);
          do_req(1, $urandom_range(0, 3) != 0, {2'b11, 17'($urandom)}, 8'($urandom), l);
          drop(1);
        end
      end
      begin
        int l;
        repeat (NRND) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          @(negedge clk);
          do_req(2, 1'($urandom), {15'h0, 4'($urandom)}, 8'($urandom), l);
          drop(2);
        end
      end
      begin
        int l;
        repeat (NRND) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          do_req(3, 1'b0, {2'b01, 17'($urandom)}, 8'h00, l);
          drop(3);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("p_queue_empty", 32'(exp_p_q.size()), 32'd0);
    check("c_queue_empty", 32'(exp_c_q.size()), 32'd0);
    check("v_queue_empty", 32'(exp_v_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACC_CYCLES, default 2, number of clocks per SRAM access with strobes active; legal range 2..15.
REQ-002 Parameter STARVE, default 8, number of clocks a pending video request waits before it is promoted above the CPU.
REQ-003 clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 p_req/p_we  in  1/1  programmer (flash loader) request and write-select.
REQ-006 p_add/p_di  in  19/8  programmer address and write data.
REQ-007 p_ack  out  1  one-clock completion pulse for the programmer.
REQ-008 c_req/c_we  in  1/1  CPU request and write-select.
REQ-009 c_add/c_di  in  19/8  CPU address and write data.
REQ-010 c_do/c_ack  out  8/1  CPU read data register and one-clock completion pulse.
REQ-011 v_req/v_add  in  1/19  video fetch request (read-only) and address.
REQ-012 v_do/v_ack  out  8/1  video read data register and one-clock completion pulse.
REQ-013 ER_ADD/ER_DO/ER_DI  out/out/in  19/8/8  SRAM address, write data and read data.
REQ-014 ER_DOE  out  1  data-bus drive enable; tristating happens at top level.
REQ-015 ER_CS/ER_OE/ER_WE  out  1 each  SRAM strobes, active low.
REQ-016 grant  out  2  current owner: 0 none, 1 programmer, 2 CPU, 3 video.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS and ACK.
REQ-018 In IDLE the block SHALL sample requests, pick a winner, latch its address, data and we, and enter ACCESS on the next clock.
REQ-019 Default priority SHALL be programmer > CPU > video.
REQ-020 When the starvation counter equals STARVE, video SHALL win over the CPU but never over the programmer.
REQ-021 Starvation counter: increments each clock that v_req=1 and video is not granted, saturates at STARVE, and clears when video is granted or v_req=0.
REQ-022 ACCESS SHALL last exactly ACC_CYCLES clocks with ER_CS=0 and ER_ADD held at the latched address.
REQ-023 Read access: ER_OE=0 for all ACCESS clocks; ER_DI is captured into the winner's do register on the last ACCESS clock.
REQ-024 Write access: ER_DOE=1 and ER_DO held for all ACCESS clocks; ER_WE=0 for every ACCESS clock except the last.
REQ-025 Write access: ER_OE SHALL stay 1.
REQ-026 ACK SHALL last one clock with all strobes high and ER_DOE=0; it pulses the winner's ack, then returns to IDLE.
REQ-027 Latency: a request seen in IDLE at clock N SHALL be acked at clock N+ACC_CYCLES+1.
REQ-028 In ACK, new do data SHALL already be valid; do registers hold their value until the next read for that requester.
REQ-029 Requesters hold req and operands stable until ack.
REQ-030 A req still high in the IDLE clock after ack SHALL be treated as a new request.
REQ-031 A request arriving while not in IDLE SHALL wait; requests SHALL never be dropped except by reset.
REQ-032 A p_we=1 or c_we=1 request is a write; the video request is always a read.
REQ-033 grant SHALL be nonzero from the first ACCESS clock through ACK, and 0 in IDLE.
REQ-034 At most one ack SHALL be high in any clock.
REQ-035 Simultaneous requests from all three SHALL be served in priority order, back-to-back.
REQ-036 Back-to-back grants SHALL have exactly one IDLE clock between them.

Reset
REQ-037 When rst=1, the block SHALL enter IDLE on the next edge.
REQ-038 Reset values: ER_CS=ER_OE=ER_WE=1, ER_DOE=0, all acks 0, grant 0, starvation counter 0, c_do=v_do=8'h00, ER_ADD 0, ER_DO 0.
REQ-039 rst asserted during ACCESS SHALL abort the access with no ack; the interrupted request is re-arbitrated after reset if still asserted.

Verification
REQ-040 CPU read 19'h0F800 with ER_DI=8'hC3, ACC_CYCLES=2 -> ER_OE low for 2 clocks, c_ack at N+3, c_do=8'hC3.
REQ-041 Programmer write 19'h7FFFF with data 8'hA5 -> ER_WE low for exactly 1 clock, ER_DOE high for 2 clocks, ER_DO=8'hA5, p_ack at N+3.
REQ-042 p_req, c_req and v_req raised together -> grant sequence 1,2,3, with one IDLE clock between grants.
REQ-043 c_req held continuously with v_req=1 -> video granted no later than the first arbitration after STARVE=8 waiting clocks.
REQ-044 rst pulsed in the second ACCESS clock of a CPU write -> no c_ack, strobes high and ER_DOE=0 on the next clock, grant=0.
REQ-045 Any random traffic -> ER_WE and ER_OE never low together, and acks are one-hot or zero.
